ccip_c1_wr_arbiter: RTL and testbench
=====================================

# ccip_c1_wr_arbiter

Round-robin arbiter that shares the single CCI-P c1 (memory write) request channel between NUM_REQ AFU datapath engines, such as result writers and status writers. It honours c1TxAlmFull backpressure and bounds the number of writes in flight. It tags each write with the requester index in mdata, so write responses are routed back as per-requester completion pulses. It sits between the AFU engines and sTx.c1 / sRx.c1, and drives registered outputs only.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, legal range 2..16.
- MAX_OUTSTANDING, 64: maximum writes issued but not yet acknowledged, legal range 1..1023.
- CNT_W, $clog2(MAX_OUTSTANDING+1): width of the outstanding counter (derived).

Ports:
- clk  in  1  CCI-P clock (pClk); the only clock.
- reset  in  1  synchronous, active-high (pck_cp2af_softReset).
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*42  cache-line address; requester i occupies bits [42i+41:42i].
- req_data  in  NUM_REQ*512  line data, packed the same way as req_addr.
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- wr_done  out  NUM_REQ  one-cycle completion pulse per requester.
- c1_alm_full  in  1  registered sRx.c1TxAlmFull.
- c1_tx_valid  out  1  drives sTx.c1.valid.
- c1_tx_addr  out  42  drives hdr.address.
- c1_tx_mdata  out  16  drives hdr.mdata.
- c1_tx_sop  out  1  drives hdr.sop.
- c1_tx_data  out  512  drives sTx.c1.data.
- c1_rsp_valid  in  1  registered sRx.c1.rspValid, for a single-line write response.
- c1_rsp_mdata  in  16  registered sRx.c1.hdr.mdata.
- outstanding  out  CNT_W  number of writes in flight.
- idle  out  1  high when outstanding==0, c1_tx_valid==0 and no req_valid is set.
- err_underflow  out  1  sticky error flag.

## Operation
- Grant condition: !c1_alm_full && (outstanding < MAX_OUTSTANDING) && (|req_valid).
- Grant selection: the first set req_valid bit found by scanning from rr_ptr upward, wrapping modulo NUM_REQ. req_ready is one-hot on the granted bit and zero otherwise.
- Handshake: a transfer occurs when req_valid[g] && req_ready[g]. Requesters hold valid, addr and data stable until ready is asserted. A requester must not drop valid without a grant.
- On a transfer:
  - Capture addr and data into the output registers.
  - Set c1_tx_mdata = {zeros, g}.
  - Set rr_ptr <= (g+1) mod NUM_REQ.
  - Increment outstanding.
- With no transfer, c1_tx_valid <= 0. Address and data outputs hold their last values.
- c1_tx_sop = c1_tx_valid, because every write is single-beat.
- Response handling: on c1_rsp_valid, decrement outstanding. If mdata[3:0] < NUM_REQ, pulse wr_done[mdata[3:0]] on the next cycle. An out-of-range index still decrements but produces no pulse.
- Issue and response in the same cycle leave outstanding unchanged.
- Response arriving with outstanding==0: the counter stays at 0 and err_underflow sets. The flag clears only on reset.
- Reset values: c1_tx_valid=0, c1_tx_sop=0, c1_tx_addr=0, c1_tx_mdata=0, c1_tx_data=0, req_ready=0, wr_done=0, outstanding=0, rr_ptr=0, err_underflow=0, idle=1.
- Reset mid-operation: any pending output write is dropped and state clears. Software must quiesce the AFU before issuing reset. Responses to writes issued before reset will raise err_underflow.

## Timing
- Request to c1_tx_valid latency is 1 cycle, so back-to-back grants produce one write per cycle.
- A c1_alm_full sampled high in cycle t means no grant in cycle t. The write registered from cycle t-1 still issues, which is legal under the CCI-P almost-full slack.
- outstanding reflects an issue or response one cycle after the handshake or rsp_valid.
- wr_done follows c1_rsp_valid by 1 cycle.
- The counter limit check uses the registered outstanding value, so the count never exceeds MAX_OUTSTANDING.

## Configuration
- Macro: CCI_WR_ARB_RSP_TRACK_EN.
- Defined: response tracking, the outstanding limit, wr_done-from-response and err_underflow are all as described above.
- Undefined:
  - The outstanding counter is removed and the grant condition drops the outstanding term.
  - wr_done[g] pulses in the same cycle that c1_tx_valid issues requester g's write.
  - c1_rsp_* inputs are ignored.
  - outstanding is tied to 0 and err_underflow to 0.

## Test plan
- Single requester: req 0 writes addr 0x100 with data 0x2A. Expect c1_tx_valid one cycle later with addr 0x100, mdata 0 and sop 1. After the response with mdata 0, expect a wr_done[0] pulse and outstanding back to 0.
- Fairness: all 4 requesters held valid for 8 cycles. Expect the grant order 0,1,2,3,0,1,2,3 and 8 consecutive c1_tx_valid cycles.
- Backpressure: c1_alm_full high for 5 cycles while req 2 is valid. Expect no req_ready for those 5 cycles, then a grant in the first cycle after alm_full falls.
- Limit: with MAX_OUTSTANDING=2 and no responses, expect exactly 2 writes and then no grants. One response releases exactly one more grant.
- Simultaneous events: an issue and a response in the same cycle keep outstanding constant. A response with outstanding=0 sets err_underflow, and the counter stays 0.
- Reset mid-stream: assert reset with outstanding=3 and c1_tx_valid=1. Expect all outputs at their reset values on the next cycle and grants restarting from requester 0.

Source files
------------

// File: rtl/ccip_c1_wr_arbiter.sv
// Round-robin arbiter sharing the CCI-P c1 write channel between NUM_REQ engines.
// Define CCI_WR_ARB_RSP_TRACK_EN to enable response tracking (outstanding limit, wr_done from responses, err_underflow).
module ccip_c1_wr_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 64,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*42-1:0]  req_addr,
    input  logic [NUM_REQ*512-1:0] req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     wr_done,
    input  logic                   c1_alm_full,
    output logic                   c1_tx_valid,
    output logic [41:0]            c1_tx_addr,
    output logic [15:0]            c1_tx_mdata,
    output logic                   c1_tx_sop,
    output logic [511:0]           c1_tx_data,
    input  logic                   c1_rsp_valid,
    input  logic [15:0]            c1_rsp_mdata,
    output logic [CNT_W-1:0]       outstanding,
    output logic                   idle,
    output logic                   err_underflow
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_found;
    logic               limit_ok;
    logic               fire;
    logic               tx_valid_q, tx_valid_d;
    logic [41:0]        tx_addr_q, tx_addr_d;
    logic [15:0]        tx_mdata_q, tx_mdata_d;
    logic [511:0]       tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0] wr_done_q, wr_done_d;
    logic [CNT_W-1:0]   outstanding_q;

    // Scan from rr_ptr upward, wrapping, for the first active requester.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr_q;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

`ifdef CCI_WR_ARB_RSP_TRACK_EN
    assign limit_ok = (outstanding_q < CNT_W'(MAX_OUTSTANDING));
`else
    assign limit_ok = 1'b1;
`endif

    assign fire = !reset && !c1_alm_full && gnt_found && limit_ok;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = fire && (gnt_idx == IDX_W'(i));
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        tx_valid_d = fire;
        tx_addr_d  = tx_addr_q;
        tx_mdata_d = tx_mdata_q;
        tx_data_d  = tx_data_q;
        if (fire) begin
            rr_ptr_d   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            tx_addr_d  = req_addr[int'(gnt_idx)*42 +: 42];
            tx_data_d  = req_data[int'(gnt_idx)*512 +: 512];
            tx_mdata_d = 16'(gnt_idx);
        end
    end

`ifdef CCI_WR_ARB_RSP_TRACK_EN
    logic [CNT_W-1:0] outstanding_d;
    logic             err_q, err_d;
    logic [3:0]       rsp_idx;
    logic             unused_rsp_hi;

    assign rsp_idx       = c1_rsp_mdata[3:0];
    assign unused_rsp_hi = ^c1_rsp_mdata[15:4];

    // Completion pulses come from responses; out-of-range tags only decrement.
    always_comb begin
        wr_done_d     = '0;
        outstanding_d = outstanding_q;
        err_d         = err_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            wr_done_d[i] = c1_rsp_valid && (rsp_idx == 4'(i));
        end
        if (fire && !c1_rsp_valid) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!fire && c1_rsp_valid) begin
            if (outstanding_q == '0) err_d = 1'b1;
            else                     outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign err_underflow = err_q;
`else
    logic unused_rsp;

    assign unused_rsp    = c1_rsp_valid ^ (^c1_rsp_mdata);
    assign outstanding_q = '0;
    assign err_underflow = 1'b0;

    // Without response tracking, completion is signalled as the write issues.
    always_comb begin
        wr_done_d = req_ready;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_addr_q  <= '0;
            tx_mdata_q <= '0;
            tx_data_q  <= '0;
            wr_done_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            tx_valid_q <= tx_valid_d;
            tx_addr_q  <= tx_addr_d;
            tx_mdata_q <= tx_mdata_d;
            tx_data_q  <= tx_data_d;
            wr_done_q  <= wr_done_d;
        end
    end

    assign c1_tx_valid = tx_valid_q;
    assign c1_tx_sop   = tx_valid_q;
    assign c1_tx_addr  = tx_addr_q;
    assign c1_tx_mdata = tx_mdata_q;
    assign c1_tx_data  = tx_data_q;
    assign wr_done     = wr_done_q;
    assign outstanding = outstanding_q;
    assign idle        = (outstanding_q == '0) && !tx_valid_q && !(|req_valid);
endmodule

// File: tb/tb_ccip_c1_wr_arbiter.sv
// Directed self-checking bench for ccip_c1_wr_arbiter (default and CCI_WR_ARB_RSP_TRACK_EN builds).
module tb_ccip_c1_wr_arbiter;
    localparam int NUM_REQ = 4;
`ifdef CCI_WR_ARB_RSP_TRACK_EN
    localparam int MAX_OUT = 3;
`else
    localparam int MAX_OUT = 64;
`endif
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic                   clk;
    logic                   reset;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*42-1:0]  req_addr;
    logic [NUM_REQ*512-1:0] req_data;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ-1:0]     wr_done;
    logic                   c1_alm_full;
    logic                   c1_tx_valid;
    logic [41:0]            c1_tx_addr;
    logic [15:0]            c1_tx_mdata;
    logic                   c1_tx_sop;
    logic [511:0]           c1_tx_data;
    logic                   c1_rsp_valid;
    logic [15:0]            c1_rsp_mdata;
    logic [CNT_W-1:0]       outstanding;
    logic                   idle;
    logic                   err_underflow;

    int checks   = 0;
    int failures = 0;

    ccip_c1_wr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_ready(req_ready),
        .wr_done(wr_done),
        .c1_alm_full(c1_alm_full),
        .c1_tx_valid(c1_tx_valid),
        .c1_tx_addr(c1_tx_addr),
        .c1_tx_mdata(c1_tx_mdata),
        .c1_tx_sop(c1_tx_sop),
        .c1_tx_data(c1_tx_data),
        .c1_rsp_valid(c1_rsp_valid),
        .c1_rsp_mdata(c1_rsp_mdata),
        .outstanding(outstanding),
        .idle(idle),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic set_req(input int i, input logic [41:0] a, input logic [511:0] d);
        req_addr[i*42 +: 42]   = a;
        req_data[i*512 +: 512] = d;
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_tx_valid"}, 512'(c1_tx_valid), 512'(0));
        chk({pfx, "_tx_sop"}, 512'(c1_tx_sop), 512'(0));
        chk({pfx, "_tx_addr"}, 512'(c1_tx_addr), 512'(0));
        chk({pfx, "_tx_mdata"}, 512'(c1_tx_mdata), 512'(0));
        chk({pfx, "_tx_data"}, c1_tx_data, 512'(0));
        chk({pfx, "_ready"}, 512'(req_ready), 512'(0));
        chk({pfx, "_wr_done"}, 512'(wr_done), 512'(0));
        chk({pfx, "_outstanding"}, 512'(outstanding), 512'(0));
        chk({pfx, "_err"}, 512'(err_underflow), 512'(0));
        chk({pfx, "_idle"}, 512'(idle), 512'(1));
    endtask

    initial begin
        logic [3:0] exp_oh;
        reset        = 1'b1;
        req_valid    = '0;
        req_addr     = '0;
        req_data     = '0;
        c1_alm_full  = 1'b0;
        c1_rsp_valid = 1'b0;
        c1_rsp_mdata = '0;
        tick();
        tick();
        chk_reset_state("rst");
        reset = 1'b0;
        tick();

        // Fairness: all four requesters held valid for eight grants.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 42'(32'h200 + i), 512'(32'hDA7A0000 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
`ifdef CCI_WR_ARB_RSP_TRACK_EN
            c1_rsp_valid = (k > 0);
            c1_rsp_mdata = 16'((k + 3) % 4);
`endif
            #1;
            exp_oh = 4'(1 << (k % 4));
            chk("fair_ready", 512'(req_ready), 512'(exp_oh));
            tick();
            chk("fair_valid", 512'(c1_tx_valid), 512'(1));
            chk("fair_mdata", 512'(c1_tx_mdata), 512'(k % 4));
            chk("fair_addr", 512'(c1_tx_addr), 512'(32'h200 + (k % 4)));
            chk("fair_data", c1_tx_data, 512'(32'hDA7A0000 + (k % 4)));
`ifdef CCI_WR_ARB_RSP_TRACK_EN
            chk("fair_outstanding", 512'(outstanding), 512'(1));
`else
            chk("fair_wr_done", 512'(wr_done), 512'(exp_oh));
`endif
        end
        req_valid = 4'b0000;
`ifdef CCI_WR_ARB_RSP_TRACK_EN
        c1_rsp_valid = 1'b1;
        c1_rsp_mdata = 16'd3;
`endif
        #1;
        chk("fair_end_ready", 512'(req_ready), 512'(0));
        tick();
        chk("fair_end_valid", 512'(c1_tx_valid), 512'(0));
`ifdef CCI_WR_ARB_RSP_TRACK_EN
        chk("fair_end_outstanding", 512'(outstanding), 512'(0));
        chk("fair_end_wr_done", 512'(wr_done), 512'(4'b1000));
`else
        chk("fair_end_wr_done", 512'(wr_done), 512'(0));
`endif
        c1_rsp_valid = 1'b0;
        tick();

        // Single requester write.
        set_req(0, 42'h100, 512'h2A);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 512'(req_ready), 512'(4'b0001));
        tick();
        chk("single_valid", 512'(c1_tx_valid), 512'(1));
        chk("single_addr", 512'(c1_tx_addr), 512'(42'h100));
        chk("single_mdata", 512'(c1_tx_mdata), 512'(0));
        chk("single_sop", 512'(c1_tx_sop), 512'(1));
        chk("single_data", c1_tx_data, 512'h2A);
`ifdef CCI_WR_ARB_RSP_TRACK_EN
        chk("single_outstanding", 512'(outstanding), 512'(1));
        c1_rsp_valid = 1'b1;
        c1_rsp_mdata = 16'd0;
`else
        chk("single_wr_done", 512'(wr_done), 512'(4'b0001));
`endif
        req_valid = 4'b0000;
        tick();
        chk("single_valid_drop", 512'(c1_tx_valid), 512'(0));
        chk("single_sop_drop", 512'(c1_tx_sop), 512'(0));
        chk("single_addr_hold", 512'(c1_tx_addr), 512'(42'h100));
`ifdef CCI_WR_ARB_RSP_TRACK_EN
        chk("single_rsp_wr_done", 512'(wr_done), 512'(4'b0001));
        chk("single_rsp_outstanding", 512'(outstanding), 512'(0));
`else
        chk("single_wr_done_clear", 512'(wr_done), 512'(0));
`endif
        c1_rsp_valid = 1'b0;
        tick();
        chk("single_idle", 512'(idle), 512'(1));
        chk("single_wr_done_quiet", 512'(wr_done), 512'(0));

        // Backpressure: alm_full high for five cycles with requester 2 waiting.
        set_req(2, 42'h3C0, 512'h55);
        req_valid   = 4'b0100;
        c1_alm_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", 512'(req_ready), 512'(0));
            tick();
            chk("bp_valid", 512'(c1_tx_valid), 512'(0));
        end
        c1_alm_full = 1'b0;
        #1;
        chk("bp_release_ready", 512'(req_ready), 512'(4'b0100));
        tick();
        chk("bp_valid_issue", 512'(c1_tx_valid), 512'(1));
        chk("bp_mdata", 512'(c1_tx_mdata), 512'(2));
        chk("bp_addr", 512'(c1_tx_addr), 512'(42'h3C0));
        req_valid = 4'b0000;
`ifdef CCI_WR_ARB_RSP_TRACK_EN
        c1_rsp_valid = 1'b1;
        c1_rsp_mdata = 16'd2;
        tick();
        chk("bp_rsp_wr_done", 512'(wr_done), 512'(4'b0100));
        chk("bp_rsp_outstanding", 512'(outstanding), 512'(0));
        c1_rsp_valid = 1'b0;
`else
        chk("bp_wr_done", 512'(wr_done), 512'(4'b0100));
        tick();
        chk("bp_wr_done_clear", 512'(wr_done), 512'(0));
`endif

        // Pointer now at 3: requesters 0 and 1 valid must wrap to 0 first.
        set_req(0, 42'h040, 512'hA0);
        set_req(1, 42'h080, 512'hA1);
        req_valid = 4'b0011;
        #1;
        chk("wrap_ready", 512'(req_ready), 512'(4'b0001));
        tick();
        chk("wrap_mdata0", 512'(c1_tx_mdata), 512'(0));
        chk("wrap_addr0", 512'(c1_tx_addr), 512'(42'h040));
        req_valid = 4'b0010;
        #1;
        chk("wrap_ready1", 512'(req_ready), 512'(4'b0010));
        tick();
        chk("wrap_mdata1", 512'(c1_tx_mdata), 512'(1));
        chk("wrap_data1", c1_tx_data, 512'hA1);
        req_valid = 4'b0000;

`ifdef CCI_WR_ARB_RSP_TRACK_EN
        // Limit of 3: third write fills the budget, then grants stop.
        chk("lim_outstanding2", 512'(outstanding), 512'(2));
        set_req(3, 42'h0C0, 512'hA3);
        req_valid = 4'b1000;
        #1;
        chk("lim_ready3", 512'(req_ready), 512'(4'b1000));
        tick();
        chk("lim_outstanding3", 512'(outstanding), 512'(3));
        req_valid = 4'b0001;
        #1;
        chk("lim_block_ready", 512'(req_ready), 512'(0));
        tick();
        chk("lim_block_valid", 512'(c1_tx_valid), 512'(0));
        chk("lim_block_outstanding", 512'(outstanding), 512'(3));
        c1_rsp_valid = 1'b1;
        c1_rsp_mdata = 16'd1;
        #1;
        chk("lim_rsp_ready", 512'(req_ready), 512'(0));
        tick();
        chk("lim_rsp_outstanding", 512'(outstanding), 512'(2));
        chk("lim_rsp_wr_done", 512'(wr_done), 512'(4'b0010));
        c1_rsp_valid = 1'b0;
        #1;
        chk("lim_release_ready", 512'(req_ready), 512'(4'b0001));
        tick();
        chk("lim_release_outstanding", 512'(outstanding), 512'(3));
        chk("lim_release_mdata", 512'(c1_tx_mdata), 512'(0));
        #1;
        chk("lim_again_ready", 512'(req_ready), 512'(0));
`else
        // Response inputs are ignored in this build.
        c1_rsp_valid = 1'b1;
        c1_rsp_mdata = 16'd0;
        tick();
        chk("ign_wr_done", 512'(wr_done), 512'(0));
        chk("ign_err", 512'(err_underflow), 512'(0));
        chk("ign_outstanding", 512'(outstanding), 512'(0));
        c1_rsp_valid = 1'b0;
        req_valid = 4'b0100;
        #1;
        chk("pre_rst_ready", 512'(req_ready), 512'(4'b0100));
        tick();
`endif

        // Reset with a write on the channel.
        chk("pre_rst_valid", 512'(c1_tx_valid), 512'(1));
        reset     = 1'b1;
        req_valid = 4'b0000;
        tick();
        chk_reset_state("midrst");
        req_valid = 4'b0010;
        #1;
        chk("midrst_ready_gated", 512'(req_ready), 512'(0));
        reset     = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("restart_ready", 512'(req_ready), 512'(4'b0001));
        tick();
        chk("restart_valid", 512'(c1_tx_valid), 512'(1));
        chk("restart_mdata", 512'(c1_tx_mdata), 512'(0));

`ifdef CCI_WR_ARB_RSP_TRACK_EN
        // Issue and response together, then underflow.
        chk("sim_outstanding1", 512'(outstanding), 512'(1));
        req_valid    = 4'b0010;
        c1_rsp_valid = 1'b1;
        c1_rsp_mdata = 16'd0;
        #1;
        chk("sim_ready", 512'(req_ready), 512'(4'b0010));
        tick();
        chk("sim_outstanding_hold", 512'(outstanding), 512'(1));
        chk("sim_wr_done", 512'(wr_done), 512'(4'b0001));
        chk("sim_err", 512'(err_underflow), 512'(0));
        req_valid    = 4'b0000;
        c1_rsp_mdata = 16'd1;
        tick();
        chk("sim_drain_outstanding", 512'(outstanding), 512'(0));
        chk("sim_drain_wr_done", 512'(wr_done), 512'(4'b0010));
        c1_rsp_mdata = 16'd5;
        tick();
        chk("uf_outstanding", 512'(outstanding), 512'(0));
        chk("uf_err", 512'(err_underflow), 512'(1));
        chk("uf_oor_wr_done", 512'(wr_done), 512'(0));
        c1_rsp_valid = 1'b0;
        tick();
        chk("uf_err_sticky", 512'(err_underflow), 512'(1));
        chk("uf_idle", 512'(idle), 512'(1));
`else
        req_valid = 4'b0000;
        chk("restart_wr_done", 512'(wr_done), 512'(4'b0001));
        tick();
        chk("end_idle", 512'(idle), 512'(1));
        chk("end_err", 512'(err_underflow), 512'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
